seq_restoring_divider: RTL and testbench

Multi-cycle unsigned integer divider producing one quotient bit per clock with a restoring shift-and-subtract algorithm. It is the inverse companion to the adder and multiplier blocks in this library. Its trial-subtract datapath is a carry-bypass subtractor, the borrow-form counterpart of the library's carry-bypass adder. A start/done handshake lets it sit behind a simple controller or testbench driver.

---
 rtl/seq_restoring_divider_pkg.sv | 14 +
 rtl/seq_restoring_divider_if.sv | 21 ++
 rtl/seq_restoring_divider_cbp_subtractor.sv | 48 ++++
 rtl/seq_restoring_divider.sv | 89 ++++++++
 tb/tb_seq_restoring_divider.sv | 151 +++++++++++++++
 5 files changed

// File: rtl/seq_restoring_divider_pkg.sv
// Shared types and helpers for the sequential restoring divider.
package divider_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Bits per carry-bypass group in the trial subtractor.
  localparam int GRP_W = 4;

  // Iteration counter width for a given operand width.
  function automatic int cnt_w(input int w);
    return $clog2(w);
  endfunction

endpackage

// File: rtl/seq_restoring_divider_if.sv
// Start/done request-response bundle between a driver and the divider.
interface seq_restoring_divider_if #(parameter int WIDTH = 8);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider_cbp_subtractor.sv
// Carry-bypass subtractor: diff = a - b computed as a + ~b + 1, borrow = ~carry_out.
module cbp_subtractor
  import divider_pkg::*;
#(
  parameter int N = 9
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic [N-1:0] diff,
  output logic         borrow
);

  localparam int NG = (N + GRP_W - 1) / GRP_W;
  localparam int NP = NG * GRP_W;

  // Padding a with 0 and ~b with 1 makes the pad bits pure propagate, so the
  // carry leaving the padded top equals the carry out of bit N-1.
  logic [NP-1:0] ap, bp, sp;
  logic          c, cin_g, allp, p, carry;

  assign ap = NP'(a);
  assign bp = ~(NP'(b));

  // Ripple inside each group; skip the group's ripple carry when all bits propagate.
  always_comb begin
    sp    = '0;
    c     = 1'b1;
    cin_g = 1'b1;
    allp  = 1'b1;
    p     = 1'b0;
    for (int g = 0; g < NG; g++) begin
      cin_g = c;
      allp  = 1'b1;
      for (int k = 0; k < GRP_W; k++) begin
        p                 = ap[g*GRP_W+k] ^ bp[g*GRP_W+k];
        sp[g*GRP_W+k]     = p ^ c;
        c                 = (ap[g*GRP_W+k] & bp[g*GRP_W+k]) | (p & c);
        allp              = allp & p;
      end
      if (allp) c = cin_g;
    end
    carry = c;
  end

  assign diff   = sp[N-1:0];
  assign borrow = ~carry;

endmodule

// File: rtl/seq_restoring_divider.sv
// Unsigned restoring divider, one quotient bit per clock, start/done handshake.
module seq_restoring_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  seq_restoring_divider_if.slave bus
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state, state_n;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   r_q;
  logic [WIDTH-1:0] q_q, dsr_q;
  logic [WIDTH:0]   r_sh, diff;
  logic             borrow, accept, last, div0;

  // Shift the next dividend bit into the partial remainder, then trial-subtract.
  assign r_sh = {r_q[WIDTH-1:0], q_q[WIDTH-1]};

  cbp_subtractor #(.N(WIDTH+1)) u_sub (
    .a      (r_sh),
    .b      ({1'b0, dsr_q}),
    .diff   (diff),
    .borrow (borrow)
  );

  assign last   = (cnt == CW'(WIDTH-1));
  assign accept = bus.start && (state != RUN);
  assign div0   = (bus.divisor == '0);

  // Next-state: a zero divisor short-circuits straight to DONE.
  always_comb begin
    state_n = state;
    case (state)
      IDLE, DONE: state_n = accept ? (div0 ? DONE : RUN) : IDLE;
      RUN:        if (last) state_n = DONE;
      default:    state_n = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Datapath, counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt             <= '0;
      r_q             <= '0;
      q_q             <= '0;
      dsr_q           <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.busy <= (state_n == RUN);
      bus.done <= (state_n == DONE);
      if (accept) begin
        dsr_q           <= bus.divisor;
        cnt             <= '0;
        r_q             <= '0;
        q_q             <= bus.dividend;
        bus.div_by_zero <= 1'b0;
        if (div0) begin
          bus.quotient    <= '1;
          bus.remainder   <= bus.dividend;
          bus.div_by_zero <= 1'b1;
        end
      end else if (state == RUN) begin
        cnt <= cnt + 1'b1;
        r_q <= borrow ? r_sh : diff;
        q_q <= {q_q[WIDTH-2:0], ~borrow};
        if (last) begin
          bus.quotient  <= {q_q[WIDTH-2:0], ~borrow};
          bus.remainder <= borrow ? r_sh[WIDTH-1:0] : diff[WIDTH-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed and random checks of the sequential divider against a q=a/b, r=a%b scoreboard.
module tb_seq_restoring_divider;

  localparam int W = 8;

  typedef struct {
    int q;
    int r;
    int dbz;
    int lat;
    int nb;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  seq_restoring_divider_if #(.WIDTH(W)) dif();

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive a start at the current negedge and record the expected result.
  task automatic launch(input int a, input int b);
    exp_t e;
    dif.start    = 1'b1;
    dif.dividend = a[W-1:0];
    dif.divisor  = b[W-1:0];
    if (b == 0) begin
      e.q = (1 << W) - 1; e.r = a; e.dbz = 1; e.lat = 1; e.nb = 0;
    end else begin
      e.q = a / b; e.r = a % b; e.dbz = 0; e.lat = W + 1; e.nb = W;
    end
    sb.push_back(e);
    @(negedge clk);
    dif.start = 1'b0;
  endtask

  // Wait (bounded) for done, optionally pulsing an ignored start at cycle inj.
  task automatic wait_done(input int inj = 0, input int ia = 0, input int ib = 0);
    int   n;
    int   nb;
    exp_t e;
    n  = 1;
    nb = dif.busy ? 1 : 0;
    while (!dif.done && n < 40) begin
      if (n == inj) begin
        dif.start    = 1'b1;
        dif.dividend = ia[W-1:0];
        dif.divisor  = ib[W-1:0];
      end else begin
        dif.start = 1'b0;
      end
      @(negedge clk);
      n++;
      if (dif.busy) nb++;
    end
    dif.start = 1'b0;
    check("done_seen", 32'(dif.done), 1);
    check("sb_level", sb.size(), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("quotient",    32'(dif.quotient),    e.q);
      check("remainder",   32'(dif.remainder),   e.r);
      check("div_by_zero", 32'(dif.div_by_zero), e.dbz);
      check("latency",     n,                    e.lat);
      check("busy_cycles", nb,                   e.nb);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_busy"}, 32'(dif.busy), 0);
    check({tag, "_done"}, 32'(dif.done), 0);
    check({tag, "_q"},    32'(dif.quotient), 0);
    check({tag, "_r"},    32'(dif.remainder), 0);
    check({tag, "_dbz"},  32'(dif.div_by_zero), 0);
  endtask

  initial begin
    int a;
    int b;
    rst          = 1'b1;
    dif.start    = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;
    repeat (2) @(negedge clk);
    check_zero_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Basic division and single-cycle done pulse.
    launch(100, 7); wait_done();
    @(negedge clk);
    check("done_pulse", 32'(dif.done), 0);
    check("q_held", 32'(dif.quotient), 14);

    launch(255, 1); wait_done();
    launch(5, 9);   wait_done();
    launch(200, 200); wait_done();
    @(negedge clk);

    // Divide by zero.
    launch(37, 0); wait_done();
    @(negedge clk);
    check("dbz_held", 32'(dif.div_by_zero), 1);

    // Start while busy is ignored; back-to-back start in the done cycle is taken.
    launch(100, 7); wait_done(3, 50, 5);
    launch(50, 5);  wait_done();
    @(negedge clk);

    // Reset mid-run clears everything immediately.
    launch(100, 7);
    sb.delete();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero_outputs("midrun_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    launch(9, 2); wait_done();

    // Random operands, run back-to-back, with occasional zero divisors.
    for (int i = 0; i < 2000; i++) begin
      a = int'($urandom_range(0, 255));
      b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 255));
      launch(a, b);
      wait_done();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
